// File: rtl/data_writer.sv
// data_writer: accepts DATASIZE-bit packets on a valid/ready handshake and
// writes each one as ascending 32-bit words to the shared memory write port.
// After WORDS words it pulses DONE_WRITING. It then holds off until the reader
// has drained memory: OutOfData must go low, then high again.
// Optional build macro DW_ZEROFILL_EN adds a flush input. A flush zero-pads the
// rest of the current batch and completes it early.
module data_writer #(
    parameter int unsigned DATASIZE = 192,
    parameter int unsigned WORDS    = 96
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATASIZE-1:0] pktIn,
    input  logic                pktValid,
    output logic                pktReady,
    input  logic                OutOfData,
`ifdef DW_ZEROFILL_EN
    input  logic                flush,
`endif
    output logic                DONE_WRITING,
    output logic [31:0]         addrB,
    output logic [31:0]         dataB,
    output logic                weB,
    output logic                busy
);

    localparam int unsigned WPP   = DATASIZE / 32;
    localparam int unsigned CNT_W = $clog2(WORDS + 1);
    localparam int unsigned IDX_W = (WPP > 1) ? $clog2(WPP) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPP - 1);

`ifdef DW_ZEROFILL_EN
    typedef enum logic [2:0] {FILL, WRITE, DONE, WAITLOW, WAITHIGH, PAD} state_t;
`else
    typedef enum logic [2:0] {FILL, WRITE, DONE, WAITLOW, WAITHIGH} state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;
    logic [IDX_W-1:0]    word_idx_q, word_idx_d;
    logic [DATASIZE-1:0] shift_q, shift_d;
    logic                pkt_ready_q, pkt_ready_d;
    logic                done_q, done_d;
    logic                we_q, we_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         addr_q, addr_d;
    logic                busy_q, busy_d;

    // Next-state, counters and registered-output values derived from the next state
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        word_idx_d   = word_idx_q;
        shift_d      = shift_q;

        unique case (state_q)
            FILL: begin
                if (pktValid && pkt_ready_q) begin
                    shift_d    = pktIn;
                    word_idx_d = '0;
                    state_d    = WRITE;
                end
`ifdef DW_ZEROFILL_EN
                else if (flush && (word_count_q != '0)) begin
                    state_d = PAD;
                end
`endif
            end
            WRITE: begin
                shift_d      = shift_q >> 32;
                word_idx_d   = word_idx_q + IDX_W'(1);
                word_count_d = word_count_q + CNT_W'(1);
                if (word_idx_q == LAST_IDX) begin
                    state_d = (word_count_q == LAST_CNT) ? DONE : FILL;
                end
            end
            DONE: begin
                word_count_d = '0;
                state_d      = WAITLOW;
            end
            WAITLOW: begin
                if (!OutOfData) state_d = WAITHIGH;
            end
            WAITHIGH: begin
                if (OutOfData) state_d = FILL;
            end
`ifdef DW_ZEROFILL_EN
            PAD: begin
                word_count_d = word_count_q + CNT_W'(1);
                if (word_count_q == LAST_CNT) state_d = DONE;
            end
`endif
            default: state_d = FILL;
        endcase

        // Outputs are registered, so they are decoded from the upcoming state
`ifdef DW_ZEROFILL_EN
        we_d = (state_d == WRITE) || (state_d == PAD);
`else
        we_d = (state_d == WRITE);
`endif
        data_d      = (state_d == WRITE) ? shift_d[31:0] : 32'd0;
        addr_d      = 32'({word_count_d, 2'b00});
        done_d      = (state_d == DONE);
        pkt_ready_d = (state_d == FILL);
        busy_d      = (state_d != FILL);
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            word_count_q <= '0;
            word_idx_q   <= '0;
            shift_q      <= '0;
            pkt_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            we_q         <= 1'b0;
            data_q       <= '0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            word_idx_q   <= word_idx_d;
            shift_q      <= shift_d;
            pkt_ready_q  <= pkt_ready_d;
            done_q       <= done_d;
            we_q         <= we_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            busy_q       <= busy_d;
        end
    end

    assign pktReady     = pkt_ready_q;
    assign DONE_WRITING = done_q;
    assign weB          = we_q;
    assign dataB        = data_q;
    assign addrB        = addr_q;
    assign busy         = busy_q;

endmodule

// File: doc/data_writer.md
Name: data_writer

Overview:
- Producer-side partner of the packet reader that serves DATASIZE-bit packets to the BSMODS compute modules.
- Accepts whole DATASIZE-bit packets over a valid/ready handshake and serializes each into 32-bit words on the shared memory write port.
- Once a full batch of WORDS words is stored, pulses DONE_WRITING, then blocks until the reader has drained memory (OutOfData low, then high again) before accepting the next batch.

Parameters:
- DATASIZE, 192, packet width in bits; must be a multiple of 32; WPP = DATASIZE/32 words per packet (default 6).
- WORDS, 96, words per batch; must be a multiple of WPP (default 16 packets); must match the reader's drain count.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pktIn  input  DATASIZE  packet to store; word 0 = pktIn[31:0].
- pktValid  input  1  pktIn valid.
- pktReady  output  1  block can accept a packet this cycle.
- OutOfData  input  1  reader status; high = reader idle/empty.
- DONE_WRITING  output  1  single-cycle pulse: batch complete.
- addrB  output  32  byte address of current write = {wordCount, 2'b00}.
- dataB  output  32  write data.
- weB  output  1  write enable for addrB/dataB this cycle.
- busy  output  1  high in any state other than FILL.

Behaviour:
- States: FILL, WRITE, DONE, WAITLOW, WAITHIGH. Reset -> FILL.
- Reset values: wordCount=0, wordIdx=0, shift register=0, pktReady=1, DONE_WRITING=0, weB=0, dataB=0, addrB=0, busy=0.
- Reset mid-operation: the partial batch is abandoned and no DONE_WRITING pulse is emitted; the next batch restarts at address 0.
- FILL:
  - pktReady=1.
  - On pktValid&&pktReady, capture pktIn into the shift register, clear wordIdx, go to WRITE.
  - No write occurs in FILL.
- WRITE:
  - pktReady=0, weB=1, dataB=shift[31:0], addrB={wordCount,2'b00}.
  - Each cycle: shift the register right by 32, wordIdx++, wordCount++.
  - After the write with wordIdx==WPP-1: go to DONE if wordCount+1==WORDS, else go to FILL.
  - A packet accepted at edge N is written in cycles N+1..N+WPP, ascending addresses, with no gaps.
- Throughput: 1 packet per WPP+1 cycles; pktValid held during WRITE is ignored until FILL.
- DONE:
  - DONE_WRITING=1 for exactly one cycle.
  - wordCount cleared to 0.
  - Go to WAITLOW.
- WAITLOW: stay until OutOfData==0 (reader has entered its serving state), then go to WAITHIGH.
- WAITHIGH: stay until OutOfData==1 (reader has drained all WORDS words), then go to FILL.
- No packet is accepted and no write occurs in DONE, WAITLOW or WAITHIGH. This guarantees the reader's region is never overwritten mid-read.
- If OutOfData is already low on entering WAITLOW, WAITLOW still lasts at least one cycle.
- Counter widths:
  - wordCount is $clog2(WORDS+1) bits, zero-extended into addrB[31:2].
  - wordIdx is $clog2(WPP) bits.
  - No wrap-around: wordCount is cleared in DONE before it can exceed WORDS-1.
- busy = (state != FILL).

Optional Feature:
- Macro: DW_ZEROFILL_EN.
- Enabled:
  - Adds input flush (1 bit).
  - In FILL, when flush==1 and pktValid==0, enter state PAD: weB=1, dataB=0, addrB={wordCount,2'b00}, wordCount++ each cycle until wordCount reaches WORDS, then go to DONE.
  - pktReady=0 in PAD.
  - flush with wordCount==0 is ignored.
  - pktValid and flush together: the packet takes priority; flush must be re-sampled later.
- Disabled: no flush port, no PAD state; a batch completes only after WORDS/WPP packets.

Test Plan:
- Reset then one packet (words 1..6, word0=1 in [31:0]): pktReady drops for 6 cycles; weB high 6 consecutive cycles; addrB 0,4,...,20; dataB 1..6; no DONE_WRITING.
- 16 back-to-back packets (pktValid held high): 96 writes, last addrB=380; DONE_WRITING high exactly one cycle after the final write; busy=1 from then on.
- After DONE_WRITING:
  - Hold OutOfData=1 for 5 cycles: pktValid is not accepted.
  - Drop OutOfData to 0 for 10 cycles, then raise it to 1: FILL is re-entered one cycle later.
  - Next packet writes start at addrB=0.
- OutOfData=0 already when DONE fires: WAITLOW is exited after one cycle; the block still waits for OutOfData rising before pktReady=1.
- Assert reset during WRITE of packet 3 (wordCount=14): all outputs return to reset values immediately; next packet writes addrB=0; no DONE_WRITING.
- DW_ZEROFILL_EN: 2 packets, then flush pulse: 84 zero writes at addrB 48..380, then DONE_WRITING pulse; flush with wordCount==0 causes no writes.
